// File: rtl/divider_arbiter.sv
// Round-robin front end that shares one unsigned iterative divider among several requesters.
// Signs, divide-by-zero, signed overflow and small dividends are resolved here without the core.
module divider_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_dividend_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_divisor_i,
  input  logic [NUM_REQ-1:0]            req_signed_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [$clog2(NUM_REQ)-1:0]    rsp_id_o,
  output logic [DATA_WIDTH-1:0]         rsp_quotient_o,
  output logic [DATA_WIDTH-1:0]         rsp_remainder_o,
  output logic                          rsp_div_by_zero_o,
  output logic [DATA_WIDTH-1:0]         div_dividend_o,
  output logic [DATA_WIDTH-1:0]         div_divisor_o,
  output logic                          div_valid_o,
  input  logic [DATA_WIDTH-1:0]         div_quotient_i,
  input  logic [DATA_WIDTH-1:0]         div_remainder_i,
  input  logic                          div_valid_i,
  input  logic                          div_idle_i
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int MSB = DATA_WIDTH - 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PREPARE = 3'd1;
  localparam logic [2:0] S_LAUNCH  = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_FIXUP   = 3'd4;
  localparam logic [2:0] S_RESPOND = 3'd5;

  localparam logic [IDW:0]          NUM_REQ_W = (IDW+1)'(NUM_REQ);
  localparam logic [DATA_WIDTH-1:0] MOST_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [2:0]            state_q;
  logic [IDW-1:0]        ptr_q;
  logic [IDW-1:0]        id_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic                  signed_q;
  logic [DATA_WIDTH-1:0] mag_a_q;
  logic [DATA_WIDTH-1:0] mag_b_q;
  logic                  qneg_q;
  logic                  rneg_q;
  logic [DATA_WIDTH-1:0] quot_q;
  logic [DATA_WIDTH-1:0] rem_q;
  logic                  dbz_q;

  logic [DATA_WIDTH-1:0] dividend_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] divisor_arr  [NUM_REQ];

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      dividend_arr[k] = req_dividend_i[k*DATA_WIDTH +: DATA_WIDTH];
      divisor_arr[k]  = req_divisor_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Search upward from the requester after the last one served, wrapping at NUM_REQ.
  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic [IDW:0]   cand;
  logic           grant_fire;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(i);
      if (cand >= NUM_REQ_W) begin
        cand = cand - NUM_REQ_W;
      end
      if (!grant_found && req_valid_i[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

  assign grant_fire = (state_q == S_IDLE) && grant_found;

  always_comb begin
    req_ready_o = '0;
    if (grant_fire) begin
      req_ready_o[grant_idx] = 1'b1;
    end
  end

  logic                  a_neg;
  logic                  b_neg;
  logic [DATA_WIDTH-1:0] abs_a;
  logic [DATA_WIDTH-1:0] abs_b;
  logic                  is_zero;
  logic                  is_ovf;
  logic                  is_small;

  // The most negative value negates to itself, which is the correct unsigned magnitude.
  always_comb begin
    a_neg    = signed_q & a_q[MSB];
    b_neg    = signed_q & b_q[MSB];
    abs_a    = a_neg ? -a_q : a_q;
    abs_b    = b_neg ? -b_q : b_q;
    is_zero  = (b_q == '0);
    is_ovf   = signed_q && (a_q == MOST_NEG) && (b_q == '1);
    is_small = (abs_a < abs_b);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      ptr_q    <= IDW'(NUM_REQ - 1);
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      quot_q   <= '0;
      rem_q    <= '0;
      dbz_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_fire) begin
            a_q      <= dividend_arr[grant_idx];
            b_q      <= divisor_arr[grant_idx];
            signed_q <= req_signed_i[grant_idx];
            id_q     <= grant_idx;
            ptr_q    <= grant_idx;
            state_q  <= S_PREPARE;
          end
        end
        S_PREPARE: begin
          mag_a_q <= abs_a;
          mag_b_q <= abs_b;
          qneg_q  <= signed_q & (a_q[MSB] ^ b_q[MSB]);
          rneg_q  <= a_neg;
          dbz_q   <= is_zero;
          if (is_zero) begin
            quot_q  <= '1;
            rem_q   <= a_q;
            state_q <= S_RESPOND;
          end else if (is_ovf) begin
            quot_q  <= a_q;
            rem_q   <= '0;
            state_q <= S_RESPOND;
          end else if (is_small) begin
            quot_q  <= '0;
            rem_q   <= a_q;
            state_q <= S_RESPOND;
          end else begin
            state_q <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          if (div_idle_i) begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (div_valid_i) begin
            quot_q  <= div_quotient_i;
            rem_q   <= div_remainder_i;
            state_q <= S_FIXUP;
          end
        end
        S_FIXUP: begin
          quot_q  <= qneg_q ? -quot_q : quot_q;
          rem_q   <= rneg_q ? -rem_q : rem_q;
          state_q <= S_RESPOND;
        end
        S_RESPOND: begin
          if (rsp_ready_i) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid_o       = (state_q == S_RESPOND);
  assign rsp_id_o          = id_q;
  assign rsp_quotient_o    = quot_q;
  assign rsp_remainder_o   = rem_q;
  assign rsp_div_by_zero_o = dbz_q;

  assign div_valid_o    = (state_q == S_LAUNCH) && div_idle_i;
  assign div_dividend_o = mag_a_q;
  assign div_divisor_o  = mag_b_q;

endmodule

// File: tb/tb_divider_arbiter.sv
// Bench for divider_arbiter: directed cases plus random traffic against a signed-division reference
// and a round-robin model, with a stand-in iterative core that takes DATA_WIDTH cycles.
module tb_divider_arbiter;

  localparam int DW       = 16;
  localparam int NR       = 4;
  localparam int IDW      = 2;
  localparam int CORE_LAT = DW;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NR-1:0]     req_valid_i;
  logic [NR-1:0]     req_ready_o;
  logic [NR*DW-1:0]  req_dividend_i;
  logic [NR*DW-1:0]  req_divisor_i;
  logic [NR-1:0]     req_signed_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [IDW-1:0]    rsp_id_o;
  logic [DW-1:0]     rsp_quotient_o;
  logic [DW-1:0]     rsp_remainder_o;
  logic              rsp_div_by_zero_o;
  logic [DW-1:0]     div_dividend_o;
  logic [DW-1:0]     div_divisor_o;
  logic              div_valid_o;
  logic [DW-1:0]     div_quotient_i;
  logic [DW-1:0]     div_remainder_i;
  logic              div_valid_i;
  logic              div_idle_i;

  logic [DW-1:0] dvd [NR];
  logic [DW-1:0] dvs [NR];

  for (genvar k = 0; k < NR; k++) begin : g_pack
    assign req_dividend_i[k*DW +: DW] = dvd[k];
    assign req_divisor_i[k*DW +: DW]  = dvs[k];
  end

  divider_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_dividend_i(req_dividend_i), .req_divisor_i(req_divisor_i), .req_signed_i(req_signed_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
    .rsp_quotient_o(rsp_quotient_o), .rsp_remainder_o(rsp_remainder_o),
    .rsp_div_by_zero_o(rsp_div_by_zero_o),
    .div_dividend_o(div_dividend_o), .div_divisor_o(div_divisor_o), .div_valid_o(div_valid_o),
    .div_quotient_i(div_quotient_i), .div_remainder_i(div_remainder_i),
    .div_valid_i(div_valid_i), .div_idle_i(div_idle_i)
  );

  always #5 clk_i = ~clk_i;

  int vec_count       = 0;
  int miscompare_count = 0;
  int div_pulses      = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompare_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain signed/unsigned division plus the special cases resolved without the core.
  function automatic void model_div(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic s,
                                    output logic [DW-1:0] q, output logic [DW-1:0] r,
                                    output logic dbz, output logic loc,
                                    output logic [DW-1:0] ma, output logic [DW-1:0] mb);
    int sa, sb, aa, ab;
    if (s) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
    end else begin
      sa = int'(a);
      sb = int'(b);
    end
    aa  = (sa < 0) ? -sa : sa;
    ab  = (sb < 0) ? -sb : sb;
    ma  = DW'(aa);
    mb  = DW'(ab);
    dbz = (b == '0);
    if (b == '0) begin
      q = '1; r = a; loc = 1'b1;
    end else if (s && a == 16'h8000 && b == 16'hFFFF) begin
      q = 16'h8000; r = '0; loc = 1'b1;
    end else begin
      q   = DW'(sa / sb);
      r   = DW'(sa % sb);
      loc = (aa < ab);
    end
  endfunction

  // Stand-in core: busy for CORE_LAT cycles after a start, then one result pulse.
  logic    force_busy = 1'b0;
  int      core_cnt   = 0;
  logic    core_start;
  logic [DW-1:0] core_a, core_b;

  initial begin
    div_valid_i = 1'b0; div_idle_i = 1'b1; div_quotient_i = '0; div_remainder_i = '0;
    core_a = '0; core_b = '1;
    forever begin
      @(negedge clk_i);
      core_start = div_valid_o && div_idle_i;
      if (core_start) begin
        core_a = div_dividend_o;
        core_b = div_divisor_o;
      end
      @(posedge clk_i);
      #2;
      div_valid_i = 1'b0;
      if (core_start) begin
        core_cnt = CORE_LAT;
      end else if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) begin
          div_valid_i     = 1'b1;
          div_quotient_i  = (core_b == '0) ? '1 : core_a / core_b;
          div_remainder_i = (core_b == '0) ? core_a : core_a % core_b;
        end
      end
      div_idle_i = (core_cnt == 0) && !div_valid_i && !force_busy;
    end
  end

  int            cyc = 0;
  bit            m_busy = 1'b0, m_local, m_launched, m_dbz;
  int            m_ptr = NR - 1, m_id, m_grant_cyc, m_res_cyc, eg, rr_c;
  logic [DW-1:0] m_q, m_r, m_ma, m_mb;
  logic [NR-1:0] exp_ready;
  bit            exp_launch, exp_rsp;

  // Every-cycle comparison of all handshake outputs against the transaction-level model.
  always @(negedge clk_i) begin
    cyc++;
    if (rst_i) begin
      m_busy = 1'b0;
      m_ptr  = NR - 1;
    end else begin
      exp_ready = '0;
      eg = -1;
      if (!m_busy) begin
        for (int i = 1; i <= NR; i++) begin
          rr_c = (m_ptr + i) % NR;
          if (eg < 0 && req_valid_i[rr_c]) eg = rr_c;
        end
      end
      if (eg >= 0) exp_ready[eg] = 1'b1;
      checkOutput("req_ready", req_ready_o, exp_ready);

      exp_launch = m_busy && !m_local && !m_launched && (cyc >= m_grant_cyc + 2) && div_idle_i;
      checkOutput("div_valid", div_valid_o, exp_launch);
      if (m_busy && !m_local && (cyc >= m_grant_cyc + 2) && m_res_cyc < 0) begin
        checkOutput("div_dividend", div_dividend_o, m_ma);
        checkOutput("div_divisor", div_divisor_o, m_mb);
      end

      exp_rsp = m_busy && (m_local ? (cyc >= m_grant_cyc + 2) : (m_res_cyc >= 0 && cyc >= m_res_cyc + 2));
      checkOutput("rsp_valid", rsp_valid_o, exp_rsp);
      if (exp_rsp) begin
        checkOutput("rsp_id", rsp_id_o, m_id);
        checkOutput("rsp_quotient", rsp_quotient_o, m_q);
        checkOutput("rsp_remainder", rsp_remainder_o, m_r);
        checkOutput("rsp_dbz", rsp_div_by_zero_o, m_dbz);
      end

      if (div_valid_o) div_pulses++;
      if (m_busy && m_launched && m_res_cyc < 0 && div_valid_i) m_res_cyc = cyc;
      if (exp_launch) m_launched = 1'b1;
      if (exp_rsp && rsp_ready_i) begin
        m_busy = 1'b0;
      end else if (eg >= 0) begin
        model_div(dvd[eg], dvs[eg], req_signed_i[eg], m_q, m_r, m_dbz, m_local, m_ma, m_mb);
        m_busy      = 1'b1;
        m_id        = eg;
        m_ptr       = eg;
        m_grant_cyc = cyc;
        m_launched  = 1'b0;
        m_res_cyc   = -1;
      end
    end
  end

  task automatic applyStimulus(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic s);
    req_valid_i     = '0;
    req_valid_i[id] = 1'b1;
    dvd[id]         = a;
    dvs[id]         = b;
    req_signed_i[id] = s;
  endtask

  task automatic do_reset();
    @(posedge clk_i); #1;
    rst_i = 1'b1; req_valid_i = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  task automatic run_one(input string tag, input int id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic s, input logic [DW-1:0] eq, input logic [DW-1:0] er, input logic edbz,
                         input int ecore, input int elat, input int stall);
    int p0, n;
    bit got;
    @(posedge clk_i); #1;
    p0 = div_pulses;
    rsp_ready_i = 1'b1;
    if (stall > 0) force_busy = 1'b1;
    applyStimulus(id, a, b, s);
    got = 1'b0;
    for (int t = 0; t < 60 && !got; t++) begin
      @(negedge clk_i);
      got = req_ready_o[id];
    end
    checkOutput({tag, "_grant"}, got, 1);
    @(posedge clk_i); #1;
    req_valid_i = '0;
    for (int t = 0; t < stall; t++) begin
      @(negedge clk_i);
      checkOutput({tag, "_stall"}, div_valid_o, 0);
    end
    if (stall > 0) begin
      @(posedge clk_i); #1;
      force_busy = 1'b0;
    end
    got = 1'b0;
    n = stall;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk_i);
      n++;
      got = rsp_valid_o;
    end
    checkOutput({tag, "_rsp_seen"}, got, 1);
    if (elat > 0) checkOutput({tag, "_latency"}, n, elat);
    checkOutput({tag, "_q"}, rsp_quotient_o, eq);
    checkOutput({tag, "_r"}, rsp_remainder_o, er);
    checkOutput({tag, "_dbz"}, rsp_div_by_zero_o, edbz);
    checkOutput({tag, "_id"}, rsp_id_o, id);
    @(posedge clk_i); #1;
    checkOutput({tag, "_core_uses"}, div_pulses - p0, ecore);
  endtask

  function automatic logic [DW-1:0] pick();
    case ($urandom % 8)
      0:       return '0;
      1:       return 16'h8000;
      2:       return 16'hFFFF;
      3:       return DW'($urandom_range(0, 15));
      default: return DW'($urandom);
    endcase
  endfunction

  logic [DW-1:0] pq, pr, pma, pmb;
  logic          pdbz, ploc;
  int            grants[$];
  bit            got;

  initial begin
    rst_i = 1'b1; req_valid_i = '0; req_signed_i = '0; rsp_ready_i = 1'b0;
    for (int k = 0; k < NR; k++) begin dvd[k] = '0; dvs[k] = '1; end

    model_div(16'd100, 16'd7, 1'b0, pq, pr, pdbz, ploc, pma, pmb);
    checkOutput("model_100_7_q", pq, 14);
    checkOutput("model_100_7_r", pr, 2);
    model_div(16'hFFF9, 16'h0002, 1'b1, pq, pr, pdbz, ploc, pma, pmb);
    checkOutput("model_m7_2_q", pq, 16'hFFFD);
    checkOutput("model_m7_2_r", pr, 16'hFFFF);
    checkOutput("model_m7_2_mag", pma, 7);
    model_div(16'hFFFB, 16'd9, 1'b1, pq, pr, pdbz, ploc, pma, pmb);
    checkOutput("model_m5_9_r", pr, 16'hFFFB);
    checkOutput("model_m5_9_local", ploc, 1);

    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("reset_rsp_valid", rsp_valid_o, 0);
    checkOutput("reset_req_ready", req_ready_o, 0);
    checkOutput("reset_div_valid", div_valid_o, 0);
    checkOutput("reset_rsp_id", rsp_id_o, 0);
    checkOutput("reset_q", rsp_quotient_o, 0);
    checkOutput("reset_r", rsp_remainder_o, 0);
    checkOutput("reset_dbz", rsp_div_by_zero_o, 0);
    checkOutput("reset_div_data", {div_dividend_o, div_divisor_o}, 0);

    run_one("u100_7",  0, 16'd100,   16'd7,      1'b0, 16'd14,    16'd2,      1'b0, 1, 0, 0);
    run_one("s_m7_2",  2, 16'hFFF9,  16'h0002,   1'b1, 16'hFFFD,  16'hFFFF,   1'b0, 1, 0, 0);
    run_one("dbz",     1, 16'd1234,  16'd0,      1'b0, 16'hFFFF,  16'h04D2,   1'b1, 0, 2, 0);
    run_one("ovf",     1, 16'h8000,  16'hFFFF,   1'b1, 16'h8000,  16'h0000,   1'b0, 0, 2, 0);
    run_one("u5_9",    3, 16'd5,     16'd9,      1'b0, 16'd0,     16'd5,      1'b0, 0, 2, 0);
    run_one("s_m5_9",  0, 16'hFFFB,  16'd9,      1'b1, 16'd0,     16'hFFFB,   1'b0, 0, 2, 0);
    run_one("stall",   2, 16'h8000,  16'd3,      1'b1, 16'hD556,  16'hFFFE,   1'b0, 1, 0, 8);

    do_reset();
    for (int k = 0; k < NR; k++) begin dvd[k] = 16'd5; dvs[k] = 16'd9; end
    req_signed_i = '0;
    rsp_ready_i = 1'b1;
    req_valid_i = '1;
    for (int t = 0; t < 100 && grants.size() < 5; t++) begin
      @(negedge clk_i);
      for (int k = 0; k < NR; k++) if (req_ready_o[k]) grants.push_back(k);
    end
    checkOutput("rr_count", grants.size(), 5);
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("rr_grant%0d", k), (k < grants.size()) ? grants[k] : -1, k % NR);
    end
    @(posedge clk_i); #1;
    req_valid_i = '0;
    repeat (4) @(posedge clk_i);

    #1 rsp_ready_i = 1'b0;
    applyStimulus(1, 16'd50, 16'd3, 1'b0);
    got = 1'b0;
    for (int t = 0; t < 60 && !got; t++) begin @(negedge clk_i); got = req_ready_o[1]; end
    checkOutput("bp_grant", got, 1);
    @(posedge clk_i); #1;
    req_valid_i = '1;
    got = 1'b0;
    for (int t = 0; t < 100 && !got; t++) begin @(negedge clk_i); got = rsp_valid_o; end
    checkOutput("bp_rsp_seen", got, 1);
    repeat (5) begin
      @(negedge clk_i);
      checkOutput("bp_hold_valid", rsp_valid_o, 1);
      checkOutput("bp_hold_q", rsp_quotient_o, 16);
      checkOutput("bp_hold_r", rsp_remainder_o, 2);
      checkOutput("bp_hold_id", rsp_id_o, 1);
      checkOutput("bp_no_grant", req_ready_o, 0);
    end
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b1;
    req_valid_i = '0;
    repeat (3) @(posedge clk_i);

    #1 applyStimulus(0, 16'd100, 16'd7, 1'b0);
    got = 1'b0;
    for (int t = 0; t < 60 && !got; t++) begin @(negedge clk_i); got = req_ready_o[0]; end
    checkOutput("rst_grant", got, 1);
    @(posedge clk_i); #1;
    req_valid_i = '0;
    got = 1'b0;
    for (int t = 0; t < 60 && !got; t++) begin @(negedge clk_i); got = div_valid_o; end
    checkOutput("rst_launch_seen", got, 1);
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("rst_rsp_dropped", rsp_valid_o, 0);
    run_one("after_rst", 3, 16'd1000, 16'd3, 1'b0, 16'd333, 16'd1, 1'b0, 1, 0, 0);

    for (int t = 0; t < 3000; t++) begin
      @(posedge clk_i); #1;
      for (int k = 0; k < NR; k++) begin dvd[k] = pick(); dvs[k] = pick(); end
      req_signed_i = NR'($urandom);
      req_valid_i  = NR'($urandom);
      rsp_ready_i  = ($urandom % 4) != 0;
      force_busy   = ($urandom % 8) == 0;
    end
    @(posedge clk_i); #1;
    req_valid_i = '0; rsp_ready_i = 1'b1; force_busy = 1'b0;
    repeat (60) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("drain_idle", rsp_valid_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare_count);
    $finish;
  end

endmodule
